// File: rtl/addac_arbiter.sv
// addac_arbiter: round-robin sequencer sharing one addac datapath between two requesters.
// Optional grant counters are enabled by defining ADDAC_ARB_STATS_EN.
module addac_arbiter #(
    parameter int W = 4
) (
    input  logic         clk_i,
    input  logic         reset_i,
    input  logic         req0_valid_i,
    output logic         req0_ready_o,
    input  logic         req0_a_i,
    input  logic         req0_b_i,
    input  logic         req0_e_i,
    input  logic [W-1:0] req0_c_i,
    input  logic [W-1:0] req0_d_i,
    input  logic         req1_valid_i,
    output logic         req1_ready_o,
    input  logic         req1_a_i,
    input  logic         req1_b_i,
    input  logic         req1_e_i,
    input  logic [W-1:0] req1_c_i,
    input  logic [W-1:0] req1_d_i,
    output logic         resp0_valid_o,
    input  logic         resp0_ready_i,
    output logic         resp1_valid_o,
    input  logic         resp1_ready_i,
    output logic [W-1:0] resp_saida1_o,
    output logic [W-1:0] resp_saida2_o,
    output logic         dp_a_o,
    output logic         dp_b_o,
    output logic         dp_e_o,
    output logic [W-1:0] dp_c_o,
    output logic [W-1:0] dp_d_o,
    input  logic [W-1:0] dp_saida1_i,
    input  logic [W-1:0] dp_saida2_i
`ifdef ADDAC_ARB_STATS_EN
    ,
    output logic [7:0]   grant_cnt0_o,
    output logic [7:0]   grant_cnt1_o
`endif
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
    state_t       state_q;
    logic         owner_q, last_q;
    logic         a_q, b_q, e_q;
    logic [W-1:0] c_q, d_q, s1_q, s2_q;
    logic         gnt0, gnt1, done;
    // last_q breaks ties: the requester that was not served last wins
    always_comb begin
        gnt0 = (state_q == IDLE) && req0_valid_i && (!req1_valid_i || last_q);
        gnt1 = (state_q == IDLE) && req1_valid_i && (!req0_valid_i || !last_q);
        done = (state_q == RESP) && (owner_q ? resp1_ready_i : resp0_ready_i);
    end
    assign req0_ready_o  = gnt0;
    assign req1_ready_o  = gnt1;
    assign resp0_valid_o = (state_q == RESP) && !owner_q;
    assign resp1_valid_o = (state_q == RESP) && owner_q;
    assign resp_saida1_o = s1_q;
    assign resp_saida2_o = s2_q;
    assign dp_a_o        = a_q;
    assign dp_b_o        = b_q;
    assign dp_e_o        = e_q;
    assign dp_c_o        = c_q;
    assign dp_d_o        = d_q;
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            owner_q <= 1'b0;
            last_q  <= 1'b1;
            a_q     <= 1'b0;
            b_q     <= 1'b0;
            e_q     <= 1'b0;
            c_q     <= '0;
            d_q     <= '0;
            s1_q    <= '0;
            s2_q    <= '0;
        end else begin
            case (state_q)
                IDLE: if (gnt0 || gnt1) begin
                    owner_q <= gnt1;
                    a_q     <= gnt1 ? req1_a_i : req0_a_i;
                    b_q     <= gnt1 ? req1_b_i : req0_b_i;
                    e_q     <= gnt1 ? req1_e_i : req0_e_i;
                    c_q     <= gnt1 ? req1_c_i : req0_c_i;
                    d_q     <= gnt1 ? req1_d_i : req0_d_i;
                    state_q <= EXEC;
                end
                EXEC: begin
                    s1_q    <= dp_saida1_i;
                    s2_q    <= dp_saida2_i;
                    state_q <= RESP;
                end
                RESP: if (done) begin
                    last_q  <= owner_q;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
`ifdef ADDAC_ARB_STATS_EN
    logic [7:0] cnt0_q, cnt1_q;
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cnt0_q <= '0;
            cnt1_q <= '0;
        end else begin
            if (gnt0 && cnt0_q != 8'hff) cnt0_q <= cnt0_q + 8'd1;
            if (gnt1 && cnt1_q != 8'hff) cnt1_q <= cnt1_q + 8'd1;
        end
    end
    assign grant_cnt0_o = cnt0_q;
    assign grant_cnt1_o = cnt1_q;
`endif
endmodule

// File: tb/tb_addac_arbiter.sv
// tb_addac_arbiter: directed bench for addac_arbiter with a response scoreboard.
// Define ADDAC_ARB_STATS_EN to also exercise the grant counters.
module tb_addac_arbiter;
    logic clk = 1'b0;
    logic reset;
    logic req0_valid, req0_ready, req0_a, req0_b, req0_e;
    logic req1_valid, req1_ready, req1_a, req1_b, req1_e;
    logic [3:0] req0_c, req0_d, req1_c, req1_d;
    logic resp0_valid, resp0_ready, resp1_valid, resp1_ready;
    logic [3:0] resp_saida1, resp_saida2;
    logic dp_a, dp_b, dp_e;
    logic [3:0] dp_c, dp_d, dp_saida1, dp_saida2;
`ifdef ADDAC_ARB_STATS_EN
    logic [7:0] grant_cnt0, grant_cnt1;
`endif
    int total = 0;
    int passed = 0;
    logic [8:0] sb[$];

    always #5 clk = ~clk;

    assign dp_saida1 = dp_c ^ dp_d;
    assign dp_saida2 = dp_c + dp_d;

    addac_arbiter #(.W(4)) dut (
        .clk_i(clk), .reset_i(reset),
        .req0_valid_i(req0_valid), .req0_ready_o(req0_ready),
        .req0_a_i(req0_a), .req0_b_i(req0_b), .req0_e_i(req0_e),
        .req0_c_i(req0_c), .req0_d_i(req0_d),
        .req1_valid_i(req1_valid), .req1_ready_o(req1_ready),
        .req1_a_i(req1_a), .req1_b_i(req1_b), .req1_e_i(req1_e),
        .req1_c_i(req1_c), .req1_d_i(req1_d),
        .resp0_valid_o(resp0_valid), .resp0_ready_i(resp0_ready),
        .resp1_valid_o(resp1_valid), .resp1_ready_i(resp1_ready),
        .resp_saida1_o(resp_saida1), .resp_saida2_o(resp_saida2),
        .dp_a_o(dp_a), .dp_b_o(dp_b), .dp_e_o(dp_e),
        .dp_c_o(dp_c), .dp_d_o(dp_d),
        .dp_saida1_i(dp_saida1), .dp_saida2_i(dp_saida2)
`ifdef ADDAC_ARB_STATS_EN
        , .grant_cnt0_o(grant_cnt0), .grant_cnt1_o(grant_cnt1)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // expected response: {owner, c^d, (c+d) mod 16}
    task automatic push(input logic o, input logic [3:0] c, input logic [3:0] d);
        logic [3:0] x, s;
        x = c ^ d;
        s = c + d;
        sb.push_back({o, x, s});
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req0_valid = 0; req0_a = 0; req0_b = 0; req0_e = 0; req0_c = 0; req0_d = 0;
        req1_valid = 0; req1_a = 0; req1_b = 0; req1_e = 0; req1_c = 0; req1_d = 0;
        resp0_ready = 0; resp1_ready = 0;
        step();
        step();
        reset = 1'b0;
    endtask

    // response monitor: pops the scoreboard on every completed response handshake
    always @(negedge clk) begin
        if (!reset) begin
            if (resp0_valid && resp1_valid) chk("both_resp_valid", 1, 0);
            if ((resp0_valid && resp0_ready) || (resp1_valid && resp1_ready)) begin
                if (sb.size() == 0) chk("unexpected_resp", {resp1_valid, resp_saida1, resp_saida2}, 32'hdead);
                else chk("resp_owner_s1_s2", {resp1_valid, resp_saida1, resp_saida2}, sb.pop_front());
            end
        end
    end

    initial begin
        do_reset();
        chk("reset_dp", {dp_a, dp_b, dp_e, dp_c, dp_d}, 0);
        chk("reset_out", {req0_ready, req1_ready, resp0_valid, resp1_valid, resp_saida1, resp_saida2}, 0);

        // single request from requester 0
        req0_valid = 1; req0_a = 1; req0_c = 4'b0011; req0_d = 4'b0101; resp0_ready = 1;
        sb.push_back({1'b0, 4'b0110, 4'b1000});
        #1 chk("single_ready", {req0_ready, req1_ready}, 2'b10);
        step();
        req0_valid = 0;
        chk("single_exec", {req0_ready, resp0_valid, dp_a, dp_c, dp_d}, {3'b001, 4'b0011, 4'b0101});
        step();
        chk("single_resp", {resp0_valid, resp1_valid}, 2'b10);
        step();
        chk("single_idle", {resp0_valid, resp1_valid}, 0);

        // simultaneous requests after reset: 6 strictly alternating grants
        do_reset();
        req0_valid = 1; req0_c = 1; req0_d = 1; resp0_ready = 1;
        req1_valid = 1; req1_c = 7; req1_d = 9; resp1_ready = 1;
        for (int i = 0; i < 3; i++) begin
            sb.push_back({1'b0, 4'b0000, 4'b0010});
            sb.push_back({1'b1, 4'b1110, 4'b0000});
        end
        #1 chk("sim_first_grant", {req0_ready, req1_ready}, 2'b10);
        repeat (18) step();
        req0_valid = 0; req1_valid = 0;
        chk("sim_drained", sb.size(), 0);

        // backpressure on requester 1 while requester 0 waits
        req1_valid = 1; req1_c = 10; req1_d = 3; resp1_ready = 0;
        push(1, 10, 3);
        step();
        req1_valid = 0;
        req0_valid = 1; req0_c = 2; req0_d = 4; resp0_ready = 1;
        push(0, 2, 4);
        step();
        for (int i = 0; i < 5; i++) begin
            chk("bp_hold", {resp1_valid, resp0_valid, req0_ready, resp_saida1, resp_saida2}, {3'b100, 4'd9, 4'd13});
            step();
        end
        resp1_ready = 1;
        step();
        chk("bp_release", {resp1_valid, req0_ready}, 2'b01);
        step();
        req0_valid = 0;
        step();
        step();
        chk("bp_drained", sb.size(), 0);

        // lone requester 1, three back-to-back operand sets, one grant every 3 cycles
        req1_valid = 1;
        for (int i = 0; i < 3; i++) begin
            req1_c = (i == 0) ? 4'd1 : (i == 1) ? 4'd5 : 4'd15;
            req1_d = (i == 0) ? 4'd2 : (i == 1) ? 4'd5 : 4'd15;
            push(1, req1_c, req1_d);
            #1 chk("lone_grant", {req0_ready, req1_ready}, 2'b01);
            step();
            if (i == 2) req1_valid = 0;
            step();
            step();
        end
        chk("lone_drained", sb.size(), 0);

        // reset while in EXEC discards the pending result
        req0_valid = 1; req0_b = 1; req0_c = 6; req0_d = 6; resp0_ready = 1;
        step();
        reset = 1; req0_valid = 0;
        step();
        chk("rst_mid_dp", {dp_a, dp_b, dp_c, dp_d, resp0_valid, resp1_valid}, 0);
        reset = 0;
        step();
        step();
        chk("rst_mid_noresp", {resp0_valid, resp1_valid}, 0);
        req0_valid = 1; req0_c = 2; req0_d = 3;
        req1_valid = 1; req1_c = 4; req1_d = 4;
        push(0, 2, 3);
        #1 chk("rst_mid_grant", {req0_ready, req1_ready}, 2'b10);
        step();
        req0_valid = 0; req1_valid = 0;
        step();
        step();
        chk("rst_mid_drained", sb.size(), 0);

`ifdef ADDAC_ARB_STATS_EN
        do_reset();
        chk("stats_reset", {grant_cnt0, grant_cnt1}, 0);
        req0_valid = 1; req0_c = 3; req0_d = 4; resp0_ready = 1;
        for (int i = 0; i < 300; i++) push(0, 3, 4);
        repeat (899) step();
        req0_valid = 0;
        step();
        chk("stats_cnt", {grant_cnt0, grant_cnt1}, {8'd255, 8'd0});
        chk("stats_drained", sb.size(), 0);
`endif

        step();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/addac_arbiter.md
Name: addac_arbiter

Overview:
- Round-robin arbiter/sequencer that shares one combinational addac datapath between two requesters.
- Each requester hands off an operand set {a, b, c, d, e} with a valid/ready handshake.
- The arbiter drives the shared addac from registered operands, captures saida1/saida2 one cycle later, and returns them to the owning requester with a valid/ready response handshake.
- Sits between the requester logic and the single addac instance.

Parameters:
- W, 4, width of c, d, saida1, saida2 (the addac instance is 4-bit; W stays 4 when connected to it).

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-high reset
- req0_valid  in  1  requester 0 has an operand set
- req0_ready  out  1  requester 0 operands accepted this cycle
- req0_a, req0_b, req0_e  in  1 each  requester 0 single-bit operands
- req0_c, req0_d  in  W each  requester 0 vector operands
- req1_valid, req1_ready, req1_a, req1_b, req1_c, req1_d, req1_e  same as requester 0, for requester 1
- resp0_valid  out  1  result available for requester 0
- resp0_ready  in  1  requester 0 takes result
- resp1_valid  out  1  result available for requester 1
- resp1_ready  in  1  requester 1 takes result
- resp_saida1  out  W  captured saida1 (shared by both responses)
- resp_saida2  out  W  captured saida2 (shared by both responses)
- dp_a, dp_b, dp_e  out  1 each  to addac
- dp_c, dp_d  out  W each  to addac
- dp_saida1, dp_saida2  in  W each  from addac

Behaviour:
- Reset (synchronous, active-high):
  - state=IDLE, owner=0, last_grant=1 so requester 0 wins first.
  - Operand registers cleared, so all dp_* outputs are 0.
  - resp_saida1=resp_saida2=0; all ready/valid outputs 0.
- FSM states IDLE, EXEC, RESP.
- IDLE:
  - Grant selection:
    - Both valid: grant the requester != last_grant.
    - One valid: grant that one.
    - None valid: stay in IDLE.
  - reqN_ready is combinational: 1 in IDLE for the granted requester only; at most one ready per cycle.
  - On the accept edge: latch that requester's a/b/c/d/e into the operand registers, owner<=N, go to EXEC.
- EXEC: dp_* hold operand registers (stable for a full cycle). On the edge, resp_saida1<=dp_saida1, resp_saida2<=dp_saida2, go to RESP.
- RESP:
  - resp<owner>_valid=1; the other resp valid stays 0.
  - resp_saida* are stable while valid.
  - Leave RESP only when resp<owner>_ready=1: last_grant<=owner, go to IDLE.
  - No new request is accepted while in EXEC or RESP; req*_ready=0.
- Latency: accept at edge N, resp valid from cycle N+2.
- Minimum turnaround is 3 cycles per transaction (with resp_ready held high).
- dp_* keep the last operands after the transaction until the next accept; no spurious toggling.
- Operand width: c, d and saida* pass through unmodified at W bits; the arbiter does no arithmetic.
- Starvation:
  - Under continuous valid on both requesters, grants strictly alternate 0,1,0,1…
  - A lone requester is granted back-to-back.
- Valid is sampled only in IDLE; a requester may drop valid before being granted without effect.
- Reset asserted in EXEC or RESP:
  - The pending result is discarded and no resp valid is seen after the reset edge.
  - Returns to reset values, including last_grant=1.

Optional Feature:
- Macro ADDAC_ARB_STATS_EN.
- Defined:
  - Adds outputs grant_cnt0 and grant_cnt1 (8 bits each).
  - Each increments on its requester's accept edge and saturates at 255.
  - Cleared by reset.
- Not defined: ports and counters are absent; behaviour is otherwise identical.

Test Plan:
Bench stub for addac: dp_saida1 = dp_c ^ dp_d, dp_saida2 = (dp_c + dp_d) mod 16.
- Single request:
  - Stimulus: req0 c=4'b0011, d=4'b0101, resp0_ready=1.
  - Required: req0_ready pulses one cycle; resp0_valid 2 cycles later with saida1=0110, saida2=1000; resp1_valid stays 0.
- Simultaneous requests after reset:
  - Stimulus: req0 c=1,d=1 and req1 c=7,d=9, both held valid.
  - Required: req0 served first (saida2=0010), then req1 (saida1=1110, saida2=0000); grants alternate over 6 transactions.
- Response backpressure:
  - Stimulus: resp1_ready held 0 for 5 cycles.
  - Required: resp1_valid and resp_saida* stay stable; req0_ready stays 0 throughout; IDLE follows the cycle ready rises.
- Lone requester back-to-back:
  - Stimulus: only req1 valid, 3 operand sets.
  - Required: 3 grants to req1, one every 3 cycles.
- Reset mid-operation:
  - Stimulus: assert reset in EXEC.
  - Required: resp0_valid never asserts; dp_*=0 next cycle; next simultaneous request goes to req0.
- With ADDAC_ARB_STATS_EN:
  - Stimulus: 300 req0 transactions.
  - Required: grant_cnt0=255, grant_cnt1=0.
